// File: rtl/ahb_gpio_pkg.sv
// Shared definitions for the AHB-lite GPIO block.
// Holds the register byte offsets, the AHB HTRANS/HRESP encodings, the
// response FSM state type and the byte-lane helper used by the write path.
package ahb_gpio_pkg;

  // Register byte offsets (word aligned)
  localparam logic [11:0] OFS_DATA_IN    = 12'h000;
  localparam logic [11:0] OFS_DATA_OUT   = 12'h004;
  localparam logic [11:0] OFS_DIR        = 12'h008;
  localparam logic [11:0] OFS_OUT_SET    = 12'h00C;
  localparam logic [11:0] OFS_OUT_CLR    = 12'h010;
  localparam logic [11:0] OFS_IRQ_EN     = 12'h014;
  localparam logic [11:0] OFS_IRQ_TYPE   = 12'h018;
  localparam logic [11:0] OFS_IRQ_POL    = 12'h01C;
  localparam logic [11:0] OFS_IRQ_STATUS = 12'h020;

  // AHB encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Response FSM: OKAY traffic stays in ST_IDLE, a rejected access walks
  // through the two-cycle AHB error response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  // Little-endian byte enables for a transfer of 2**size bytes at addr[1:0].
  // Word and larger sizes enable all four lanes.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size,
                                            input logic [1:0] lo);
    case (size)
      3'd0:    byte_lanes = 4'b0001 << lo;
      3'd1:    byte_lanes = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears every stage
//   din   - asynchronous input bus (WIDTH bits)
//   dout  - synchronised bus, STAGES clocks behind din
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/ahb_gpio.sv
// AHB-lite GPIO slave with per-pin direction, set/clear helpers and
// level/edge interrupts.
// Ports:
//   HCLK, HRESET            - clock, synchronous active-high reset
//   HSEL..HWDATA            - AHB-lite slave address/data phase inputs
//   HREADYOUT, HRDATA, HRESP- AHB-lite slave response
//   gpio_i                  - asynchronous pad inputs
//   gpio_o, gpio_oe         - pad data and pad output enable (1 = drive)
//   irq                     - registered OR of enabled pending interrupts
//   fsm_state               - response FSM state, for observation
// Handshake: an address phase is taken when HSEL, HREADY and HTRANS[1] are
// all high; the data phase follows in the next cycle. OKAY transfers have
// zero wait states. A rejected access gets HREADYOUT=0/HRESP=1 then
// HREADYOUT=1/HRESP=1 and has no side effects.
module ahb_gpio
  import ahb_gpio_pkg::*;
#(
  parameter int NGPIO       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [11:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic             HRESP,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             irq,
  output state_e           fsm_state
);

  logic [NGPIO-1:0] sync_in, sync_hist, rise, fall, edge_set, w1c, status_nxt;
  logic [NGPIO-1:0] data_out, dir, irq_en, irq_type, irq_pol, irq_status;
  logic [NGPIO-1:0] wmask, wbits, rd_val;
  logic [3:0]       lanes;
  logic             hist_valid, wr_en;
  logic             dp_valid, dp_write;
  logic [11:0]      dp_ofs;
  logic [1:0]       dp_lo;
  logic [2:0]       dp_size;
  logic             addr_accept, addr_bad;
  state_e           state, state_nxt;

  gpio_sync #(.WIDTH(NGPIO), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (HCLK),
    .rst  (HRESET),
    .din  (gpio_i),
    .dout (sync_in)
  );

  // Address phase decode and error FSM next state. The ST_ERR1 guard
  // drops any address phase offered while HREADY is held low by our
  // own first error cycle.
  always_comb begin
    addr_accept = HSEL && HREADY && (state != ST_ERR1) &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    // Offsets are judged by word, so byte lanes of IRQ_STATUS are legal.
    addr_bad    = (HADDR[11:2] > OFS_IRQ_STATUS[11:2]) ||
                  ((HSIZE >= 3'd2) && (HADDR[1:0] != 2'b00));
    state_nxt   = ST_IDLE;
    if (state == ST_ERR1)              state_nxt = ST_ERR2;
    else if (addr_accept && addr_bad)  state_nxt = ST_ERR1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_ofs    <= '0;
      dp_lo     <= '0;
      dp_size   <= '0;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= (state_nxt != ST_ERR1);
      HRESP     <= (state_nxt == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
      dp_valid  <= addr_accept && !addr_bad;
      if (addr_accept) begin
        dp_write <= HWRITE;
        dp_ofs   <= {HADDR[11:2], 2'b00};
        dp_lo    <= HADDR[1:0];
        dp_size  <= HSIZE;
      end
    end
  end

  assign fsm_state = state;

  // Data phase write lanes, expanded from bytes to implemented bits
  always_comb begin
    lanes = byte_lanes(dp_size, dp_lo);
    wmask = '0;
    for (int i = 0; i < NGPIO; i++) wmask[i] = lanes[i/8];
    wbits = HWDATA[NGPIO-1:0] & wmask;
    wr_en = dp_valid && dp_write;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      irq_type <= '0;
      irq_pol  <= '0;
    end else if (wr_en) begin
      case (dp_ofs)
        OFS_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
        OFS_DIR:      dir      <= (dir & ~wmask) | wbits;
        OFS_OUT_SET:  data_out <= data_out | wbits;
        OFS_OUT_CLR:  data_out <= data_out & ~wbits;
        OFS_IRQ_EN:   irq_en   <= (irq_en & ~wmask) | wbits;
        OFS_IRQ_TYPE: irq_type <= (irq_type & ~wmask) | wbits;
        OFS_IRQ_POL:  irq_pol  <= (irq_pol & ~wmask) | wbits;
        default: ;
      endcase
    end
  end

  // Interrupt status. Edge bits are sticky and W1C, with a new edge
  // winning over a same-cycle clear. Level bits simply follow the pin.
  // hist_valid masks the first cycle out of reset so the history flop's
  // reset value cannot fake an edge.
  always_comb begin
    rise       = sync_in & ~sync_hist;
    fall       = ~sync_in & sync_hist;
    edge_set   = hist_valid ? (irq_type & ((irq_pol & rise) | (~irq_pol & fall))) : '0;
    w1c        = (wr_en && (dp_ofs == OFS_IRQ_STATUS)) ? wbits : '0;
    status_nxt = (irq_type & ((irq_status & ~w1c) | edge_set)) |
                 (~irq_type & ~(sync_in ^ irq_pol));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync_hist  <= '0;
      hist_valid <= 1'b0;
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      sync_hist  <= sync_in;
      hist_valid <= 1'b1;
      irq_status <= status_nxt;
      irq        <= |(irq_status & irq_en);
    end
  end

  // Read data is driven only during an OKAY read data phase
  always_comb begin
    rd_val = '0;
    case (dp_ofs)
      OFS_DATA_IN:    rd_val = sync_in;
      OFS_DATA_OUT:   rd_val = data_out;
      OFS_DIR:        rd_val = dir;
      OFS_IRQ_EN:     rd_val = irq_en;
      OFS_IRQ_TYPE:   rd_val = irq_type;
      OFS_IRQ_POL:    rd_val = irq_pol;
      OFS_IRQ_STATUS: rd_val = irq_status;
      default:        rd_val = '0;
    endcase
    HRDATA = '0;
    if (dp_valid && !dp_write) HRDATA[NGPIO-1:0] = rd_val;
  end

  assign gpio_o  = data_out;
  assign gpio_oe = dir;

  // Bits that are legitimately ignored for narrow NGPIO
  logic unused_bits;
  assign unused_bits = ^{HWDATA, lanes};

endmodule

// File: doc/ahb_gpio.md
AHB_GPIO -- requirements
Module: ahb_gpio

Interface
REQ-001 SHALL have parameter NGPIO, default 8, number of GPIO channels (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..3).
REQ-003 SHALL have port HCLK, input, 1, the block's only clock.
REQ-004 SHALL have port HRESET, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have AHB-lite slave inputs HSEL 1, HADDR 12 (offset), HTRANS 2, HSIZE 3, HWRITE 1, HREADY 1, HWDATA 32.
REQ-006 SHALL have outputs HREADYOUT 1, HRDATA 32, and HRESP 1 (0=OKAY, 1=ERROR).
REQ-007 SHALL have port gpio_i, input, NGPIO, asynchronous pad inputs.
REQ-008 SHALL have ports gpio_o and gpio_oe, output, NGPIO each, giving pad data and pad output-enable (1=drive).
REQ-009 SHALL have port irq, output, 1, registered OR of all enabled pending interrupts.

Function
REQ-010 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] are all high, registering address, write flag and HSIZE for the data phase.
REQ-011 SHALL apply a write to the register selected in the data phase, using HWDATA byte lanes enabled by HSIZE/HADDR[1:0] (little-endian).
REQ-012 SHALL return read data in the data phase with zero wait states and HREADYOUT=1, for mapped offsets.
REQ-013 SHALL implement the register map below, word offsets, bits [NGPIO-1:0] only; upper bits read 0 and ignore writes.
  0x00 DATA_IN: read-only, synchronised gpio_i.
  0x04 DATA_OUT: read/write.
  0x08 DIR: read/write, 1=output.
  0x0C OUT_SET: write-1-to-set DATA_OUT, reads 0.
  0x10 OUT_CLR: write-1-to-clear DATA_OUT, reads 0.
  0x14 IRQ_EN: read/write.
  0x18 IRQ_TYPE: read/write, 0=level, 1=edge.
  0x1C IRQ_POL: read/write, 0=low/falling, 1=high/rising.
  0x20 IRQ_STATUS: read; write-1-to-clear edge bits.
REQ-014 SHALL drive gpio_o=DATA_OUT and gpio_oe=DIR directly from registers.
REQ-015 SHALL pass gpio_i through SYNC_STAGES flops, then one further history flop for edge detection; DATA_IN latency from pad is SYNC_STAGES cycles.
REQ-016 SHALL set edge status bit n in the cycle after the synchronised bit matches the IRQ_POL edge, independent of IRQ_EN.
REQ-017 SHALL make level status bit n track (sync_in[n] == IRQ_POL[n]) every cycle; W1C on a level bit has no effect.
REQ-018 SHALL give priority to a hardware edge set over a same-cycle W1C of the same bit (bit remains 1).
REQ-019 SHALL register irq = |(IRQ_STATUS & IRQ_EN), one cycle after status changes.
REQ-020 SHALL answer any access to an offset above 0x20, or a non-word-aligned word access, with a two-cycle ERROR response. Cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1. The FSM is IDLE->ERR1->ERR2->IDLE and the access writes nothing.
REQ-021 SHALL treat IDLE/BUSY transfers and HSEL=0 as no-ops with an OKAY response.
REQ-022 SHALL discard a new address phase presented during ERR1 (HREADY low), as per AHB.
REQ-023 SHALL, when OUT_SET and OUT_CLR affect the same bit in consecutive writes, apply them in order; there is no single-cycle conflict path.

Reset
REQ-024 SHALL, while HRESET=1 at a HCLK edge, clear all registers, synchronisers, status, irq and the FSM. HRESETOUT... outputs are: HREADYOUT=1, HRESP=0, HRDATA=0, gpio_o=0, gpio_oe=0, irq=0.
REQ-025 SHALL, on reset asserted mid-transfer (including ERR1/ERR2), abandon the transfer and return the FSM to IDLE the next cycle.
REQ-026 SHALL set no edge status from the history flop's reset value in the first cycle after reset release.

Structure
REQ-027 SHALL place register offsets, the FSM state enum and the AHB HTRANS/HRESP encodings in shared package ahb_gpio_pkg.
REQ-028 SHALL instantiate sub-module gpio_sync, an NGPIO-wide SYNC_STAGES flop chain, one instance.

Verification
REQ-029 Bench SHALL check reset release -> gpio_oe=0, gpio_o=0, irq=0, and all registers read 0.
REQ-030 Bench SHALL check: write DIR=0xFF, DATA_OUT=0x0F, OUT_SET=0x30, OUT_CLR=0x01 -> gpio_o=0x3E and DATA_OUT reads 0x3E.
REQ-031 Bench SHALL check IRQ_TYPE[2]=1, POL[2]=1, EN[2]=1, then gpio_i[2] rising -> STATUS=0x04 at SYNC_STAGES+1 cycles and irq one cycle later; W1C 0x04 clears it.
REQ-032 Bench SHALL check an edge on bit 2 in the same cycle as a W1C of bit 2 -> STATUS[2] stays 1.
REQ-033 Bench SHALL check a read of offset 0x40 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles, and no register changes.
REQ-034 Bench SHALL check a byte write 0xA5 to offset 0x05 with NGPIO=16 -> DATA_OUT=0xA500.
